// File: rtl/flash_read_master.sv
// Burst read initiator for the simulation flash responder: range-checks a request, issues one
// 8-byte flash read per beat under a credit limit, and returns beats through a small response FIFO.
module flash_read_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FLASH_SIZE = 8192,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        flash_ren,
    output logic [31:0] flash_addr,
    input  logic [63:0] flash_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_last,
    output logic        resp_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [33:0] BASE34 = {2'b00, BASE_ADDR};
    localparam logic [33:0] SIZE34 = 34'(FLASH_SIZE);

    typedef enum logic [1:0] {IDLE, BUSY, ERR, DRAIN} state_t;

    state_t      state, state_nx;
    logic        reset_q;
    logic [31:0] offset;
    logic [7:0]  len;
    logic [7:0]  beat;
    logic        inflight;
    logic        inflight_last;

    logic [63:0] mem_data [FIFO_DEPTH];
    logic        mem_last [FIFO_DEPTH];
    logic        mem_err  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ;

    logic        accept;
    logic        req_err;
    logic        empty;
    logic        pop;
    logic        push;
    logic        err_push;
    logic        can_issue;
    logic [63:0] push_data;
    logic        push_last;
    logic [33:0] addr34;
    logic [33:0] span34;
    logic [CW:0] credit_used;
    logic [CW:0] credit_max;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The request window is checked in 34 bits so an end address past 4 GiB cannot wrap to "in range".
    assign addr34  = {2'b00, req_addr};
    assign span34  = ({26'd0, req_len} + 34'd1) << 3;
    assign req_err = (addr34 < BASE34) || ((addr34 - BASE34 + span34) > SIZE34);

    assign req_ready = (state == IDLE) && !reset_q;
    assign accept    = req_valid && req_ready;
    assign empty     = (occ == '0);
    assign pop       = !empty && resp_ready;

    // A beat may issue only if every buffered or in-flight beat still has a FIFO slot after this pop.
    assign credit_used = {1'b0, occ} + (CW+1)'(inflight);
    assign credit_max  = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
    assign can_issue   = credit_used < credit_max;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        flash_ren = 1'b0;
        err_push  = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = req_err ? ERR : BUSY;
            BUSY: begin
                if (can_issue) begin
                    flash_ren = 1'b1;
                    if (beat == len) state_nx = DRAIN;
                end
            end
            ERR: begin
                if (empty) begin
                    err_push = 1'b1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: if (!inflight && empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign flash_addr = flash_ren ? (offset + {21'd0, beat, 3'b000}) : 32'd0;
    assign push       = inflight || err_push;
    assign push_data  = inflight ? flash_data : 64'd0;
    assign push_last  = inflight ? inflight_last : 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            reset_q       <= 1'b1;
            offset        <= '0;
            len           <= '0;
            beat          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
        end else begin
            state         <= state_nx;
            reset_q       <= 1'b0;
            inflight      <= flash_ren;
            inflight_last <= (beat == len);
            if (accept) begin
                offset <= req_addr - BASE_ADDR;
                len    <= req_len;
                beat   <= '0;
            end else if (flash_ren) begin
                beat <= beat + 8'd1;
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and occupancy alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
            mem_err[wr_ptr]  <= err_push;
        end
    end

    assign resp_valid = !empty;
    assign resp_data  = empty ? 64'd0 : mem_data[rd_ptr];
    assign resp_last  = empty ? 1'b0  : mem_last[rd_ptr];
    assign resp_err   = empty ? 1'b0  : mem_err[rd_ptr];

    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (occ == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_flash_read_master.sv
// Randomized bench for flash_read_master: a flash image responder plus a burst-level reference
// model that predicts addresses and beats directly from the request fields.
module tb_flash_read_master;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          SIZE  = 8192;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        flash_ren;
    logic [31:0] flash_addr;
    logic [63:0] flash_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_last;
    logic        resp_err;

    flash_read_master #(.BASE_ADDR(BASE), .FLASH_SIZE(SIZE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .flash_ren(flash_ren), .flash_addr(flash_addr), .flash_data(flash_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        err;
    } beat_t;

    logic [7:0]  image [SIZE];
    beat_t       exp_q[$];
    logic [31:0] addr_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rmode = 0;
    int acc_cyc, first_ren, first_vld, last_pop;
    int issued, popped, rx_cnt, max_out;
    logic [3:0] toggle_pat = 4'b1001;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] image_word(input logic [31:0] off);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = image[(off + 32'(b)) % 32'(SIZE)];
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (flash_ren) flash_data <= image_word(flash_addr);

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = toggle_pat[cyc % 4];
                default: resp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: flash reads against the address model, response beats against the beat model.
    initial begin
        logic        held;
        beat_t       held_b;
        beat_t       e;
        held = 1'b0;
        held_b = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held = 1'b0;
                continue;
            end
            if (flash_ren) begin
                issued++;
                if (first_ren < 0) first_ren = cyc;
                if (addr_q.size() == 0) check("unexpected_ren", 64'(flash_addr), 64'hDEAD);
                else check("flash_addr", 64'(flash_addr), 64'(addr_q.pop_front()));
            end
            if (resp_valid && first_vld < 0) first_vld = cyc;
            if (held) begin
                check("stall_valid", 64'(resp_valid), 64'd1);
                check("stall_data", resp_data, held_b.data);
                check("stall_last", 64'(resp_last), 64'(held_b.last));
            end
            if (resp_valid && resp_ready) begin
                popped++;
                rx_cnt++;
                last_pop = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(rx_cnt), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", resp_data, e.data);
                    check("resp_last", 64'(resp_last), 64'(e.last));
                    check("resp_err", 64'(resp_err), 64'(e.err));
                end
            end
            held = resp_valid && !resp_ready;
            held_b = '{data: resp_data, last: resp_last, err: resp_err};
            if (issued - popped > max_out) max_out = issued - popped;
        end
    end

    // Reference model: expected flash offsets and response beats of one burst.
    function automatic logic model_err(input logic [31:0] addr, input logic [7:0] len);
        longint a = longint'(addr);
        return (a < longint'(BASE)) || (a - longint'(BASE) + 8 * (longint'(len) + 1) > longint'(SIZE));
    endfunction

    task automatic load_model(input logic [31:0] addr, input logic [7:0] len);
        logic [31:0] off;
        if (model_err(addr, len)) begin
            exp_q.push_back('{data: 64'd0, last: 1'b1, err: 1'b1});
        end else begin
            off = addr - BASE;
            for (int i = 0; i <= int'(len); i++) begin
                addr_q.push_back(off + 32'(8 * i));
                exp_q.push_back('{data: image_word(off + 32'(8 * i)), last: (i == int'(len)), err: 1'b0});
            end
        end
    endtask

    task automatic send_req(input logic [31:0] addr, input logic [7:0] len);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (n == 200) check("req_ready_timeout", 64'd0, 64'd1);
        first_ren = -1;
        first_vld = -1;
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        acc_cyc   = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input int mode,
                             input logic lat);
        logic err;
        int n;
        err = model_err(addr, len);
        rmode = mode;
        rx_cnt = 0;
        issued = 0;
        popped = 0;
        max_out = 0;
        load_model(addr, len);
        send_req(addr, len);
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && addr_q.size() == 0 && req_ready) break;
        end
        if (n == 3000) check("burst_timeout", 64'd0, 64'd1);
        repeat (4) @(negedge clk);
        check("beat_count", 64'(rx_cnt), err ? 64'd1 : 64'(int'(len) + 1));
        check("outstanding_le_depth", 64'(max_out <= DEPTH), 64'd1);
        if (err) check("err_no_ren", 64'(issued), 64'd0);
        if (lat && !err) begin
            check("ren_latency", 64'(first_ren - acc_cyc), 64'd1);
            check("vld_latency", 64'(first_vld - acc_cyc), 64'd3);
            if (mode == 0) check("back_to_back", 64'(last_pop - first_vld), 64'(len));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_flash_ren"}, 64'(flash_ren), 64'd0);
        check({tag, "_flash_addr"}, 64'(flash_addr), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_data"}, resp_data, 64'd0);
        check({tag, "_resp_last_err"}, {62'd0, resp_last, resp_err}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        int          off;
        for (int i = 0; i < SIZE; i++) image[i] = 8'($urandom);
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_len = '0;
        first_ren = -1;
        first_vld = -1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(req_ready), 64'd1);

        run_burst(BASE, 8'd0, 0, 1'b1);
        run_burst(BASE + 32'd8, 8'd3, 0, 1'b1);
        run_burst(BASE, 8'd7, 1, 1'b0);
        run_burst(BASE + 32'h1FF8, 8'd1, 0, 1'b0);
        run_burst(32'h0FFF_FFF8, 8'd0, 0, 1'b0);
        run_burst(BASE + 32'd3, 8'd0, 0, 1'b1);
        run_burst(BASE + 32'h1FF8, 8'd0, 0, 1'b1);
        run_burst(BASE, 8'd255, 2, 1'b0);

        // Reset for one cycle in the middle of a 16-beat burst.
        rmode = 0;
        load_model(BASE + 32'h100, 8'd15);
        send_req(BASE + 32'h100, 8'd15);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midreset");
        reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        run_burst(BASE + 32'h40, 8'd0, 0, 1'b1);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0: begin
                    a = $urandom;
                    l = 8'($urandom_range(0, 15));
                end
                1: begin
                    l = 8'($urandom_range(0, 7));
                    off = SIZE - 8 * (int'(l) + 1) + int'($urandom_range(0, 8));
                    a = BASE + 32'(off);
                end
                default: begin
                    l = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
                    a = BASE + 32'($urandom_range(0, SIZE - 8 * (int'(l) + 1)));
                end
            endcase
            run_burst(a, l, $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
